cpu_ctrl: RTL and testbench

Multi-cycle instruction controller for the 16-bit CPU. Fetches instructions over a shared memory port, decodes them, and sequences reg_alu by driving its control and immediate inputs. Owns the program counter and resolves branches and jumps from reg_alu's psrOut and dSrc. Data loads bypass it: memory read data goes straight to reg_alu mem_data.

---
 rtl/cpu_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute sequencer for the 16-bit CPU; drives reg_alu and owns the PC.
// Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN (illegal opcode halts the core instead of acting as a NOP).

`ifndef ALUOp_AND
`define ALUOp_AND 5'h01
`endif
`ifndef ALUOp_OR
`define ALUOp_OR  5'h02
`endif
`ifndef ALUOp_XOR
`define ALUOp_XOR 5'h03
`endif
`ifndef ALUOp_ADD
`define ALUOp_ADD 5'h05
`endif
`ifndef ALUOp_SUB
`define ALUOp_SUB 5'h09
`endif
`ifndef ALUOp_CMP
`define ALUOp_CMP 5'h0B
`endif
`ifndef ALUOp_MOV
`define ALUOp_MOV 5'h0D
`endif
`ifndef ALUOp_LUI
`define ALUOp_LUI 5'h0F
`endif
`ifndef ALUOp_SLL
`define ALUOp_SLL 5'h10
`endif
`ifndef ALUOp_SRL
`define ALUOp_SRL 5'h11
`endif
`ifndef ALUOp_SRA
`define ALUOp_SRA 5'h12
`endif

module cpu_ctrl #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] dSrc,
    input  logic [15:0] dDst,
    input  logic [4:0]  psrOut,
    output logic        write,
    output logic        IMM_MUX,
    output logic        SRAM_OUT,
    output logic        RA_BUF,
    output logic [3:0]  rSrc,
    output logic [3:0]  rDst,
    output logic [4:0]  aluOp,
    output logic [15:0] pc,
    output logic [15:0] imm,
    output logic        illegal
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

    typedef enum logic [3:0] {
        I_RALU, I_IALU, I_SHIFT, I_LOAD, I_STOR, I_JAL, I_JCOND, I_BCOND, I_ILL
    } kind_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  ir_op, ir_rd, ir_ext, ir_rs;
    logic [15:0] pc_inc, br_target;
    logic        cond_true;

    kind_e       dec_kind;
    logic [4:0]  dec_alu;
    logic [15:0] dec_imm;
    logic        dec_imm_mux;
    logic        dec_write;

    // F and L flags are produced by reg_alu but no condition code consumes them.
    logic        unused_flags;
    assign unused_flags = ^psrOut[2:1];

    assign ir_op     = ir_q[15:12];
    assign ir_rd     = ir_q[11:8];
    assign ir_ext    = ir_q[7:4];
    assign ir_rs     = ir_q[3:0];
    assign pc_inc    = pc_q + 16'd1;
    assign br_target = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};

    function automatic logic [4:0] alu_code(input logic [3:0] sel);
        case (sel)
            4'h1:    alu_code = `ALUOp_AND;
            4'h2:    alu_code = `ALUOp_OR;
            4'h3:    alu_code = `ALUOp_XOR;
            4'h5:    alu_code = `ALUOp_ADD;
            4'h9:    alu_code = `ALUOp_SUB;
            4'hB:    alu_code = `ALUOp_CMP;
            4'hD:    alu_code = `ALUOp_MOV;
            4'hF:    alu_code = `ALUOp_LUI;
            default: alu_code = 5'h00;
        endcase
    endfunction

    // Condition field shared by Jcond and Bcond; psrOut = {N,Z,F,L,C}.
    always_comb begin
        case (ir_rd)
            4'h0:    cond_true = psrOut[3];
            4'h1:    cond_true = ~psrOut[3];
            4'h2:    cond_true = psrOut[0];
            4'h3:    cond_true = ~psrOut[0];
            4'h6:    cond_true = psrOut[4];
            4'h7:    cond_true = ~psrOut[4];
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dec_kind    = I_ILL;
        dec_alu     = 5'h00;
        dec_imm     = 16'h0000;
        dec_imm_mux = 1'b0;
        dec_write   = 1'b0;
        case (ir_op)
            4'h0: begin
                if (ir_ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) begin
                    dec_kind  = I_RALU;
                    dec_alu   = alu_code(ir_ext);
                    dec_write = (ir_ext != 4'hB);
                end
            end
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF: begin
                dec_kind    = I_IALU;
                dec_alu     = alu_code(ir_op);
                dec_imm_mux = 1'b1;
                dec_write   = (ir_op != 4'hB);
                dec_imm     = (ir_op inside {4'h5, 4'h9, 4'hB}) ? {{8{ir_q[7]}}, ir_q[7:0]}
                                                                : {8'h00, ir_q[7:0]};
            end
            4'h8: begin
                if (ir_ext <= 4'h2) begin
                    dec_kind    = I_SHIFT;
                    dec_imm_mux = 1'b1;
                    dec_write   = 1'b1;
                    dec_imm     = {12'h000, ir_rs};
                    case (ir_ext)
                        4'h0:    dec_alu = `ALUOp_SLL;
                        4'h1:    dec_alu = `ALUOp_SRL;
                        default: dec_alu = `ALUOp_SRA;
                    endcase
                end
            end
            4'h4: begin
                case (ir_ext)
                    4'h0:    dec_kind = I_LOAD;
                    4'h4:    dec_kind = I_STOR;
                    4'h8:    dec_kind = I_JAL;
                    4'hC:    dec_kind = I_JCOND;
                    default: dec_kind = I_ILL;
                endcase
            end
            4'hC:    dec_kind = I_BCOND;
            default: dec_kind = I_ILL;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        write     = 1'b0;
        IMM_MUX   = 1'b0;
        SRAM_OUT  = 1'b0;
        RA_BUF    = 1'b0;
        rSrc      = 4'h0;
        rDst      = 4'h0;
        aluOp     = 5'h00;
        pc        = 16'h0000;
        imm       = 16'h0000;

        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rSrc    = ir_rs;
                rDst    = ir_rd;
                state_d = S_FETCH;
                case (dec_kind)
                    I_RALU, I_IALU, I_SHIFT: begin
                        aluOp   = dec_alu;
                        IMM_MUX = dec_imm_mux;
                        imm     = dec_imm;
                        write   = dec_write;
                        pc_d    = pc_inc;
                    end
                    I_LOAD, I_STOR: state_d = S_MEM;
                    I_JAL: begin
                        write  = 1'b1;
                        RA_BUF = 1'b1;
                        pc     = pc_inc;
                        pc_d   = dSrc;
                    end
                    I_JCOND: pc_d = cond_true ? dSrc : pc_inc;
                    I_BCOND: pc_d = cond_true ? br_target : pc_inc;
                    default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        pc_d    = pc_inc;
`endif
                    end
                endcase
            end
            S_MEM: begin
                rSrc      = ir_rs;
                rDst      = ir_rd;
                mem_req   = 1'b1;
                mem_addr  = dSrc;
                mem_we    = (dec_kind == I_STOR);
                mem_wdata = dDst;
                if (mem_ack) begin
                    write    = (dec_kind == I_LOAD);
                    SRAM_OUT = (dec_kind == I_LOAD);
                    pc_d     = pc_inc;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase

        // The state register already sits in FETCH during reset; keep the bus quiet until rst drops.
        if (rst) begin
            mem_req  = 1'b0;
            mem_addr = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 16'h0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: an instruction-level model predicts every output on every cycle.
`timescale 1ns/1ps

module tb_cpu_ctrl;

    localparam logic [15:0] PC_RST = 16'h0000;

    localparam logic [4:0] OP_AND = 5'h01, OP_OR = 5'h02, OP_XOR = 5'h03, OP_ADD = 5'h05;
    localparam logic [4:0] OP_SUB = 5'h09, OP_CMP = 5'h0B, OP_MOV = 5'h0D, OP_LUI = 5'h0F;
    localparam logic [4:0] OP_SLL = 5'h10, OP_SRL = 5'h11, OP_SRA = 5'h12;

    localparam logic [47:0] LEGAL_OPS  = {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF, 4'h8, 4'h4, 4'hC};
    localparam logic [27:0] LEGAL_RALU = {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};

    logic        clk, rst;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] dSrc, dDst;
    logic [4:0]  psrOut;
    logic        write, IMM_MUX, SRAM_OUT, RA_BUF;
    logic [3:0]  rSrc, rDst;
    logic [4:0]  aluOp;
    logic [15:0] pc, imm;
    logic        illegal;

    cpu_ctrl #(.PC_RESET(PC_RST)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dSrc(dSrc), .dDst(dDst), .psrOut(psrOut),
        .write(write), .IMM_MUX(IMM_MUX), .SRAM_OUT(SRAM_OUT), .RA_BUF(RA_BUF),
        .rSrc(rSrc), .rDst(rDst), .aluOp(aluOp), .pc(pc), .imm(imm), .illegal(illegal)
    );

    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        write;
        logic        imm_mux;
        logic        sram_out;
        logic        ra_buf;
        logic [3:0]  rsrc;
        logic [3:0]  rdst;
        logic [4:0]  aluop;
        logic [15:0] pc;
        logic [15:0] imm;
        logic        illegal;
    } obs_t;

    typedef enum {K_RALU, K_IALU, K_SHIFT, K_LOAD, K_STOR, K_JAL, K_JCOND, K_BCOND, K_ILL} kind_t;

    obs_t        act, exp_o, cap_exec, cap_mem, cap_halt;
    bit          exp_valid;
    int          n_tests, n_fail;
    int          cap_req_n, cap_wr_n;
    logic [15:0] model_pc;

    assign act = '{req: mem_req, we: mem_we, addr: mem_addr, wdata: mem_wdata, write: write,
                   imm_mux: IMM_MUX, sram_out: SRAM_OUT, ra_buf: RA_BUF, rsrc: rSrc, rdst: rDst,
                   aluop: aluOp, pc: pc, imm: imm, illegal: illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit reached", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic cmp_obs(input obs_t a, input obs_t e);
        check("mem_req",   32'(a.req),      32'(e.req));
        check("mem_we",    32'(a.we),       32'(e.we));
        check("mem_addr",  32'(a.addr),     32'(e.addr));
        check("mem_wdata", 32'(a.wdata),    32'(e.wdata));
        check("write",     32'(a.write),    32'(e.write));
        check("IMM_MUX",   32'(a.imm_mux),  32'(e.imm_mux));
        check("SRAM_OUT",  32'(a.sram_out), 32'(e.sram_out));
        check("RA_BUF",    32'(a.ra_buf),   32'(e.ra_buf));
        check("rSrc",      32'(a.rsrc),     32'(e.rsrc));
        check("rDst",      32'(a.rdst),     32'(e.rdst));
        check("aluOp",     32'(a.aluop),    32'(e.aluop));
        check("pc_out",    32'(a.pc),       32'(e.pc));
        check("imm",       32'(a.imm),      32'(e.imm));
        check("illegal",   32'(a.illegal),  32'(e.illegal));
    endtask

    always @(negedge clk) begin
        if (exp_valid) cmp_obs(act, exp_o);
    end

    // ---------------- instruction-level reference model ----------------
    function automatic kind_t classify(input logic [15:0] ins);
        logic [3:0] op, ext;
        op  = ins[15:12];
        ext = ins[7:4];
        case (op)
            4'h0:    return (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) ? K_RALU : K_ILL;
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF: return K_IALU;
            4'h8:    return (ext <= 4'h2) ? K_SHIFT : K_ILL;
            4'h4: begin
                case (ext)
                    4'h0:    return K_LOAD;
                    4'h4:    return K_STOR;
                    4'h8:    return K_JAL;
                    4'hC:    return K_JCOND;
                    default: return K_ILL;
                endcase
            end
            4'hC:    return K_BCOND;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [3:0] code);
        case (code)
            4'h1:    return OP_AND;
            4'h2:    return OP_OR;
            4'h3:    return OP_XOR;
            4'h5:    return OP_ADD;
            4'h9:    return OP_SUB;
            4'hB:    return OP_CMP;
            4'hD:    return OP_MOV;
            4'hF:    return OP_LUI;
            default: return 5'h00;
        endcase
    endfunction

    function automatic bit taken(input logic [3:0] cond, input logic [4:0] psr);
        case (cond)
            4'h0:    return psr[3];
            4'h1:    return !psr[3];
            4'h2:    return psr[0];
            4'h3:    return !psr[0];
            4'h6:    return psr[4];
            4'h7:    return !psr[4];
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic obs_t fetch_exp(input logic [15:0] pcv);
        obs_t e;
        e      = '0;
        e.req  = 1'b1;
        e.addr = pcv;
        return e;
    endfunction

    function automatic obs_t exec_exp(input logic [15:0] ins, input logic [15:0] pcv);
        obs_t       e;
        logic [3:0] op, ext;
        op     = ins[15:12];
        ext    = ins[7:4];
        e      = '0;
        e.rdst = ins[11:8];
        e.rsrc = ins[3:0];
        case (classify(ins))
            K_RALU: begin
                e.aluop = alu_of(ext);
                e.write = (ext != 4'hB);
            end
            K_IALU: begin
                e.aluop   = alu_of(op);
                e.imm_mux = 1'b1;
                e.write   = (op != 4'hB);
                e.imm     = (op == 4'h5 || op == 4'h9 || op == 4'hB) ? {{8{ins[7]}}, ins[7:0]}
                                                                     : {8'h00, ins[7:0]};
            end
            K_SHIFT: begin
                e.aluop   = (ext == 4'h0) ? OP_SLL : (ext == 4'h1) ? OP_SRL : OP_SRA;
                e.imm_mux = 1'b1;
                e.write   = 1'b1;
                e.imm     = {12'h000, ins[3:0]};
            end
            K_JAL: begin
                e.write  = 1'b1;
                e.ra_buf = 1'b1;
                e.pc     = pcv + 16'd1;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t mem_exp(input logic [15:0] ins, input logic [15:0] ds,
                                     input logic [15:0] dd, input bit ack);
        obs_t e;
        bit   is_load;
        is_load    = (classify(ins) == K_LOAD);
        e          = '0;
        e.req      = 1'b1;
        e.we       = (classify(ins) == K_STOR);
        e.addr     = ds;
        e.wdata    = dd;
        e.rdst     = ins[11:8];
        e.rsrc     = ins[3:0];
        e.write    = is_load && ack;
        e.sram_out = is_load && ack;
        return e;
    endfunction

    function automatic logic [15:0] next_pc(input logic [15:0] ins, input logic [15:0] pcv,
                                            input logic [15:0] ds, input logic [4:0] psr);
        case (classify(ins))
            K_JAL:   return ds;
            K_JCOND: return taken(ins[11:8], psr) ? ds : pcv + 16'd1;
            K_BCOND: return taken(ins[11:8], psr) ? pcv + {{8{ins[7]}}, ins[7:0]} : pcv + 16'd1;
            default: return pcv + 16'd1;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_phase(input logic [15:0] ins, input int flat);
        for (int c = 0; c <= flat; c++) begin
            mem_ack   = (c == flat);
            mem_rdata = (c == flat) ? ins : 16'($urandom);
            dSrc      = 16'($urandom);
            dDst      = 16'($urandom);
            psrOut    = 5'($urandom);
            exp_o     = fetch_exp(model_pc);
            exp_valid = 1'b1;
            step();
        end
    endtask

    task automatic exec_phase(input logic [15:0] ins, input logic [15:0] ds,
                              input logic [15:0] dd, input logic [4:0] psr);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        dSrc      = ds;
        dDst      = dd;
        psrOut    = psr;
        exp_o     = exec_exp(ins, model_pc);
        @(negedge clk);
        cap_exec = act;
        step();
    endtask

    task automatic mem_phase(input logic [15:0] ins, input int mlat,
                             input logic [15:0] ds, input logic [15:0] dd);
        cap_req_n = 0;
        cap_wr_n  = 0;
        for (int c = 0; c <= mlat; c++) begin
            mem_ack   = (c == mlat);
            mem_rdata = 16'($urandom);
            dSrc      = ds;
            dDst      = dd;
            psrOut    = 5'($urandom);
            exp_o     = mem_exp(ins, ds, dd, c == mlat);
            @(negedge clk);
            if (act.req)   cap_req_n++;
            if (act.write) cap_wr_n++;
            if (c == 0)    cap_mem = act;
            step();
        end
    endtask

    task automatic do_instr(input logic [15:0] ins, input int flat, input int mlat,
                            input logic [15:0] ds, input logic [15:0] dd, input logic [4:0] psr);
        kind_t k;
        k = classify(ins);
        fetch_phase(ins, flat);
        exec_phase(ins, ds, dd, psr);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        if (k == K_ILL) begin
            for (int h = 0; h < 4; h++) begin
                mem_ack       = 1'($urandom_range(0, 1));
                dSrc          = 16'($urandom);
                exp_o         = '0;
                exp_o.illegal = 1'b1;
                @(negedge clk);
                cap_halt = act;
                step();
            end
            rst      = 1'b1;
            mem_ack  = 1'b0;
            exp_o    = '0;
            step();
            rst      = 1'b0;
            model_pc = PC_RST;
            return;
        end
`endif
        if (k == K_LOAD || k == K_STOR) mem_phase(ins, mlat, ds, dd);
        mem_ack  = 1'b0;
        model_pc = next_pc(ins, model_pc, ds, psr);
    endtask

    function automatic logic [15:0] gen_instr();
        logic [15:0] ins;
        int          idx;
        ins = 16'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            idx = $urandom_range(0, 11);
            ins[15:12] = LEGAL_OPS[4*idx +: 4];
            if (ins[15:12] == 4'h4 && $urandom_range(0, 3) != 0) ins[7:4] = {2'($urandom), 2'b00};
            if (ins[15:12] == 4'h8 && $urandom_range(0, 3) != 0) ins[7:4] = 4'($urandom_range(0, 2));
            if (ins[15:12] == 4'h0 && $urandom_range(0, 3) != 0) begin
                idx = $urandom_range(0, 6);
                ins[7:4] = LEGAL_RALU[4*idx +: 4];
            end
        end
        return ins;
    endfunction

    initial begin
        logic [15:0] ins;
        n_tests   = 0;
        n_fail    = 0;
        exp_valid = 1'b0;
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        dSrc      = 16'h0000;
        dDst      = 16'h0000;
        psrOut    = 5'h00;
        exp_o     = '0;
        exp_valid = 1'b1;
        mem_ack   = 1'b1;
        step();
        step();
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_write",   32'(write),   32'h0);
        check("rst_imm",     32'(imm),     32'h0);
        mem_ack  = 1'b0;
        rst      = 1'b0;
        model_pc = PC_RST;

        // ADDI r1,10 with a one-cycle-late ack
        do_instr(16'h510A, 1, 0, 16'h1234, 16'h5678, 5'h00);
        check("addi_write",  32'(cap_exec.write),   32'h1);
        check("addi_immmux", 32'(cap_exec.imm_mux), 32'h1);
        check("addi_rdst",   32'(cap_exec.rdst),    32'h1);
        check("addi_aluop",  32'(cap_exec.aluop),   32'(OP_ADD));
        check("addi_imm",    32'(cap_exec.imm),     32'h000A);
        check("addi_next",   32'(mem_addr),         32'h0001);

        do_instr(16'h92FF, 0, 0, 16'h0000, 16'h0000, 5'h00);
        check("subi_imm",    32'(cap_exec.imm),     32'hFFFF);
        do_instr(16'hF2FF, 0, 0, 16'h0000, 16'h0000, 5'h00);
        check("lui_imm",     32'(cap_exec.imm),     32'h00FF);
        check("lui_aluop",   32'(cap_exec.aluop),   32'(OP_LUI));

        // STOR r1,r2 with the ack three cycles late
        do_instr(16'h4142, 0, 3, 16'hFF00, 16'h000A, 5'h00);
        check("stor_req_cycles", 32'(cap_req_n),     32'd4);
        check("stor_we",         32'(cap_mem.we),    32'h1);
        check("stor_addr",       32'(cap_mem.addr),  32'hFF00);
        check("stor_wdata",      32'(cap_mem.wdata), 32'h000A);
        check("stor_write",      32'(cap_wr_n),      32'd0);

        do_instr(16'h4302, 0, 2, 16'h0040, 16'h0000, 5'h00);
        check("load_write_cycles", 32'(cap_wr_n), 32'd1);

        // BEQ -2 at 0010, taken then not taken
        do_instr(16'h4EC0, 0, 0, 16'h0010, 16'h0000, 5'h00);
        do_instr(16'hC0FE, 0, 0, 16'h0000, 16'h0000, 5'b01000);
        check("beq_taken", 32'(mem_addr), 32'h000E);
        do_instr(16'h4EC0, 0, 0, 16'h0010, 16'h0000, 5'h00);
        do_instr(16'hC0FE, 0, 0, 16'h0000, 16'h0000, 5'b00000);
        check("beq_not_taken", 32'(mem_addr), 32'h0011);

        // JAL r5,r6 at 0020
        do_instr(16'h4EC0, 0, 0, 16'h0020, 16'h0000, 5'h00);
        do_instr(16'h4586, 0, 0, 16'h0100, 16'h0000, 5'h00);
        check("jal_rabuf",  32'(cap_exec.ra_buf), 32'h1);
        check("jal_pc",     32'(cap_exec.pc),     32'h0021);
        check("jal_target", 32'(mem_addr),        32'h0100);

        do_instr(16'h4F1F, 0, 0, 16'h0000, 16'h0000, 5'h00);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        check("ill_halt_flag", 32'(cap_halt.illegal), 32'h1);
        check("ill_halt_req",  32'(cap_halt.req),     32'h0);
        check("ill_restart",   32'(mem_addr),         32'(PC_RST));
`else
        check("ill_flag", 32'(cap_exec.illegal), 32'h0);
        check("ill_nop",  32'(mem_addr),         32'h0101);
`endif

        // PC wrap FFFF -> 0000
        do_instr(16'h4EC0, 0, 0, 16'hFFFF, 16'h0000, 5'h00);
        do_instr(16'h510A, 0, 0, 16'h0000, 16'h0000, 5'h00);
        check("pc_wrap", 32'(mem_addr), 32'h0000);

        // Reset while a store is waiting for its ack
        fetch_phase(16'h4142, 0);
        exec_phase(16'h4142, 16'hA000, 16'h5555, 5'h00);
        mem_ack = 1'b0;
        exp_o   = mem_exp(16'h4142, 16'hA000, 16'h5555, 1'b0);
        step();
        rst   = 1'b1;
        exp_o = '0;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'h0);
        check("rst_mid_we",  32'(mem_we),  32'h0);
        step();
        rst      = 1'b0;
        model_pc = PC_RST;
        #1;
        check("rst_mid_refetch", 32'(mem_addr), 32'(PC_RST));

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            do ins = gen_instr(); while (classify(ins) == K_ILL);
`else
            ins = gen_instr();
`endif
            do_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                     16'($urandom), 16'($urandom), 5'($urandom));
        end

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
